// File: rtl/l2norm_frame_ctrl.sv
// l2norm_frame_ctrl: frame sequencer feeding a sum-of-squares accumulator and holding its result
module l2norm_frame_ctrl #(
  parameter int VEC_LEN = 8,
  parameter int ACC_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        sq_clear,
  output logic        sq_valid,
  output logic [7:0]  sq_data,
  input  logic [19:0] sq_sum,
  output logic        res_valid,
  output logic [19:0] res_data,
  input  logic        res_ready,
  output logic        busy,
  output logic [4:0]  sample_cnt
);
  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] wait_cnt;
  logic xfer, last, drained;
  assign xfer    = in_valid && in_ready;
  assign last    = xfer && sample_cnt == 5'(VEC_LEN - 1);
  assign drained = state == DRAIN && wait_cnt == 3'(ACC_LAT);
  // next-state: the wait counter lets the accumulator absorb the last sample before capture
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? CLEAR : IDLE;
      CLEAR:   state_nx = ACCUM;
      ACCUM:   state_nx = last ? DRAIN : ACCUM;
      DRAIN:   state_nx = drained ? DONE : DRAIN;
      DONE:    state_nx = res_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  // registered outputs decoded from the next state so they line up with the state itself
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready   <= 1'b0;
      sq_clear   <= 1'b0;
      sq_valid   <= 1'b0;
      sq_data    <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      busy       <= 1'b0;
      sample_cnt <= '0;
      wait_cnt   <= '0;
    end else begin
      in_ready   <= state_nx == ACCUM;
      sq_clear   <= state_nx == CLEAR;
      res_valid  <= state_nx == DONE;
      busy       <= state_nx != IDLE;
      sq_valid   <= xfer;
      sq_data    <= xfer ? in_data : sq_data;
      sample_cnt <= state == CLEAR ? 5'd0 : xfer ? sample_cnt + 5'd1 : sample_cnt;
      wait_cnt   <= state == DRAIN ? wait_cnt + 3'd1 : 3'd0;
      res_data   <= drained ? sq_sum : res_data;
    end
  end
endmodule

// File: tb/tb_l2norm_frame_ctrl.sv
// tb_l2norm_frame_ctrl: randomized frame tests against a sum-of-squares reference
module tb_l2norm_frame_ctrl;
  localparam int LAT = 2;
  logic clk = 0, reset = 1, start = 0, in_valid = 0, res_ready = 0, sel = 0;
  logic [7:0] in_data = 0;
  int cyc = 0, checks = 0, errors = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic a_in_ready, a_sq_clear, a_sq_valid, a_res_valid, a_busy;
  logic b_in_ready, b_sq_clear, b_sq_valid, b_res_valid, b_busy;
  logic [7:0] a_sq_data, b_sq_data;
  logic [19:0] a_res_data, b_res_data;
  logic [4:0] a_sample_cnt, b_sample_cnt;
  logic [19:0] acc_a = 0, sum_a = 0, acc_b = 0, sum_b = 0;

  l2norm_frame_ctrl #(.VEC_LEN(8), .ACC_LAT(LAT)) dut_a (
    .clk(clk), .reset(reset), .start(start && !sel), .in_valid(in_valid), .in_data(in_data),
    .in_ready(a_in_ready), .sq_clear(a_sq_clear), .sq_valid(a_sq_valid), .sq_data(a_sq_data),
    .sq_sum(sum_a), .res_valid(a_res_valid), .res_data(a_res_data), .res_ready(res_ready),
    .busy(a_busy), .sample_cnt(a_sample_cnt));
  l2norm_frame_ctrl #(.VEC_LEN(16), .ACC_LAT(LAT)) dut_b (
    .clk(clk), .reset(reset), .start(start && sel), .in_valid(in_valid), .in_data(in_data),
    .in_ready(b_in_ready), .sq_clear(b_sq_clear), .sq_valid(b_sq_valid), .sq_data(b_sq_data),
    .sq_sum(sum_b), .res_valid(b_res_valid), .res_data(b_res_data), .res_ready(res_ready),
    .busy(b_busy), .sample_cnt(b_sample_cnt));

  // accumulator stand-ins: one cycle to accumulate plus one delay stage gives ACC_LAT=2
  always @(posedge clk) begin
    acc_a <= a_sq_clear ? 20'd0 : acc_a + (a_sq_valid ? 20'(a_sq_data) * 20'(a_sq_data) : 20'd0);
    sum_a <= acc_a;
    acc_b <= b_sq_clear ? 20'd0 : acc_b + (b_sq_valid ? 20'(b_sq_data) * 20'(b_sq_data) : 20'd0);
    sum_b <= acc_b;
  end

  logic in_ready, sq_clear, sq_valid, res_valid, busy;
  logic [7:0] sq_data;
  logic [19:0] res_data;
  logic [4:0] sample_cnt;
  logic [37:0] a_all, b_all;
  assign in_ready   = sel ? b_in_ready : a_in_ready;
  assign sq_clear   = sel ? b_sq_clear : a_sq_clear;
  assign sq_valid   = sel ? b_sq_valid : a_sq_valid;
  assign sq_data    = sel ? b_sq_data : a_sq_data;
  assign res_valid  = sel ? b_res_valid : a_res_valid;
  assign res_data   = sel ? b_res_data : a_res_data;
  assign busy       = sel ? b_busy : a_busy;
  assign sample_cnt = sel ? b_sample_cnt : a_sample_cnt;
  assign a_all = {a_in_ready, a_sq_clear, a_sq_valid, a_sq_data, a_res_valid, a_res_data, a_busy, a_sample_cnt};
  assign b_all = {b_in_ready, b_sq_clear, b_sq_valid, b_sq_data, b_res_valid, b_res_data, b_busy, b_sample_cnt};

  // monitor of the accumulator-side strobes of the selected DUT
  int n_clr = 0, n_val = 0;
  bit clr_bad = 0;
  logic [7:0] seen[$];
  always @(posedge clk) begin
    #2;
    if (sq_clear) begin
      n_clr++;
      if (n_val > 0) clr_bad = 1;
    end
    if (sq_valid) begin
      if (n_clr == 0) clr_bad = 1;
      n_val++;
      seen.push_back(sq_data);
    end
  end

  task automatic run_frame(input string name, input int n, input logic [7:0] d[16],
                           input int mode, input int hold, input bit poke);
    logic [19:0] expv = 0, held;
    int i = 0, k = 0, g = 0, t_last = 0;
    bit bad = 0;
    for (int j = 0; j < n; j++) expv += 20'(d[j]) * 20'(d[j]);
    n_clr = 0; n_val = 0; clr_bad = 0; seen.delete();
    start = 1;
    @(negedge clk);
    start = 0;
    while (i < n && k < 400) begin
      in_data = d[i];
      in_valid = mode == 0 ? 1'b1 : mode == 1 ? (k % 3 == 0) : 1'($urandom_range(0, 1));
      if (in_valid && in_ready) begin
        checks++;
        if (sample_cnt !== 5'(i)) begin errors++; $display("FAIL %s sample_cnt: got %0d want %0d", name, sample_cnt, i); end
        i++;
        t_last = cyc;
      end
      k++;
      @(negedge clk);
    end
    in_valid = 1; in_data = 8'hAA;
    checks++;
    if (i != n || in_ready !== 1'b0) begin errors++; $display("FAIL %s ready_after_last: accepted %0d in_ready %b want %0d/0", name, i, in_ready, n); end
    while (res_valid !== 1'b1 && g < 40) begin
      @(negedge clk);
      in_valid = 0;
      g++;
    end
    checks++;
    if (cyc - t_last != 2 + LAT) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, cyc - t_last, 2 + LAT); end
    checks++;
    if (res_data !== expv) begin errors++; $display("FAIL %s res_data: got %0d want %0d", name, res_data, expv); end
    checks++;
    if (sample_cnt !== 5'(n)) begin errors++; $display("FAIL %s final_cnt: got %0d want %0d", name, sample_cnt, n); end
    checks++;
    if (n_clr != 1 || clr_bad) begin errors++; $display("FAIL %s sq_clear: got %0d pulses order_bad %0d want 1/0", name, n_clr, clr_bad); end
    checks++;
    if (n_val != n) begin errors++; $display("FAIL %s sq_valid_count: got %0d want %0d", name, n_val, n); end
    for (int j = 0; j < n; j++) if (j >= seen.size() || seen[j] !== d[j]) bad = 1;
    checks++;
    if (bad) begin errors++; $display("FAIL %s sq_data_seq: got %p want first %0d of %p", name, seen, n, d); end
    for (int j = 0; j < hold; j++) begin
      held = res_data;
      start = poke;
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== held || busy !== 1'b1) begin
        errors++; $display("FAIL %s hold: got v=%b d=%0d busy=%b want 1/%0d/1", name, res_valid, res_data, busy, held);
      end
    end
    res_ready = 1; start = poke;
    @(negedge clk);
    res_ready = 0; start = 0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s release: got v=%b busy=%b want 0/0", name, res_valid, busy); end
    if (poke) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || sq_clear !== 1'b0) begin errors++; $display("FAIL %s start_ignored: got busy=%b clr=%b want 0/0", name, busy, sq_clear); end
    end
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (a_all !== '0) begin errors++; $display("FAIL reset_a: got %h want 0", a_all); end
    checks++;
    if (b_all !== '0) begin errors++; $display("FAIL reset_b: got %h want 0", b_all); end
    reset = 0;
    @(negedge clk);
    checks++;
    if (a_busy !== 1'b0 || b_busy !== 1'b0) begin errors++; $display("FAIL idle_no_start: got %b%b want 00", a_busy, b_busy); end
  endtask

  task automatic test_basic;
    logic [7:0] d[16];
    for (int j = 0; j < 16; j++) d[j] = 8'(j + 1);
    run_frame("basic", 8, d, 0, 0, 0);
  endtask

  task automatic test_max;
    logic [7:0] d[16];
    for (int j = 0; j < 16; j++) d[j] = 8'd255;
    sel = 1;
    run_frame("max16", 16, d, 0, 0, 0);
    checks++;
    if (b_res_data !== 20'hFE010) begin errors++; $display("FAIL max16_hold_value: got %h want FE010", b_res_data); end
    sel = 0;
  endtask

  task automatic test_bubbles;
    logic [7:0] d[16];
    for (int j = 0; j < 16; j++) d[j] = 8'd3;
    run_frame("bubbles", 8, d, 1, 0, 0);
  endtask

  task automatic test_backpressure;
    logic [7:0] d[16];
    for (int j = 0; j < 16; j++) d[j] = 8'($urandom);
    run_frame("backpressure", 8, d, 0, 5, 1);
  endtask

  task automatic test_reset_mid;
    logic [7:0] d[16];
    int acc = 0, k = 0;
    for (int j = 0; j < 16; j++) d[j] = 8'd0;
    start = 1;
    @(negedge clk);
    start = 0;
    while (acc < 3 && k < 50) begin
      in_valid = 1;
      in_data = 8'($urandom_range(1, 255));
      if (in_valid && in_ready) acc++;
      k++;
      @(negedge clk);
    end
    in_valid = 0; reset = 1;
    @(negedge clk);
    checks++;
    if (acc != 3 || a_all !== '0) begin errors++; $display("FAIL reset_mid: accepted %0d outputs %h want 3/0", acc, a_all); end
    reset = 0;
    @(negedge clk);
    run_frame("after_reset", 8, d, 0, 0, 0);
  endtask

  task automatic test_back_to_back;
    logic [7:0] d[16];
    for (int j = 0; j < 16; j++) d[j] = 8'(j + 1);
    run_frame("b2b_a", 8, d, 0, 0, 0);
    for (int j = 0; j < 16; j++) d[j] = 8'd2;
    run_frame("b2b_b", 8, d, 0, 0, 0);
  endtask

  task automatic test_random;
    logic [7:0] d[16];
    for (int f = 0; f < 4; f++) begin
      for (int j = 0; j < 16; j++) d[j] = 8'($urandom);
      sel = f[0];
      run_frame(f[0] ? "rand16" : "rand8", f[0] ? 16 : 8, d, 2, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    sel = 0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_max;
    test_bubbles;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
